// File: rtl/laser_pkg.sv
// Shared definitions for the multi-channel laser pulse generator:
// mode encodings, channel state enum and the cooldown counter width.
package laser_pkg;

  localparam logic [1:0] ONE_SHOT = 2'b00;
  localparam logic [1:0] RETRIG   = 2'b01;
  localparam logic [1:0] CANCEL   = 2'b10;

  localparam int COOL_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    COOL
  } chan_state_e;

  // Encoding 11 has no behaviour of its own and collapses onto one-shot.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return ((m == RETRIG) || (m == CANCEL)) ? m : ONE_SHOT;
  endfunction

endpackage

// File: rtl/laser_chan.sv
// One button/laser channel: edge-detected press starts a pulse of the
// latched duration, with one-shot / retrigger / cancel behaviour and cooldown.
module laser_chan
  import laser_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int COOLDOWN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             b,
  input  logic [CNT_W-1:0] duration,
  input  logic [1:0]       mode,
  output logic             xl,
  output logic             done
);

  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN);

  chan_state_e       state;
  logic              prev_b;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  dur_q;
  logic [1:0]        mode_q;
  logic [COOL_W-1:0] cool_cnt;
  logic              press;

  assign press = b & ~prev_b;

  // cnt holds the cycles of XL still to come including the current one,
  // so the pulse ends on the edge where it reads 1; no wrap at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      prev_b   <= 1'b1;
      cnt      <= '0;
      dur_q    <= '0;
      mode_q   <= ONE_SHOT;
      cool_cnt <= '0;
      xl       <= 1'b0;
      done     <= 1'b0;
    end else begin
      prev_b <= b;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (press && (duration != '0)) begin
            state  <= ON;
            xl     <= 1'b1;
            cnt    <= duration;
            dur_q  <= duration;
            mode_q <= norm_mode(mode);
          end
        end
        ON: begin
          if (press && (mode_q == RETRIG)) begin
            cnt <= dur_q;
          end else if ((press && (mode_q == CANCEL)) || (cnt == CNT_W'(1))) begin
            xl   <= 1'b0;
            done <= 1'b1;
            cnt  <= '0;
            if (COOL_LOAD == '0) begin
              state <= IDLE;
            end else begin
              state    <= COOL;
              cool_cnt <= COOL_LOAD;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        COOL: begin
          if (cool_cnt == COOL_W'(1)) begin
            state <= IDLE;
          end else begin
            cool_cnt <= cool_cnt - COOL_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          xl    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/laser_pulse_n.sv
// Multi-channel laser pulse generator: CHANNELS independent laser_chan
// instances sharing the clock, reset, duration and mode inputs.
module laser_pulse_n
  import laser_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int COOLDOWN = 0
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] B,
  input  logic [CNT_W-1:0]    Duration,
  input  logic [1:0]          Mode,
  output logic [CHANNELS-1:0] XL,
  output logic [CHANNELS-1:0] Done
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    laser_chan #(
      .CNT_W    (CNT_W),
      .COOLDOWN (COOLDOWN)
    ) u_chan (
      .clk      (CLK),
      .rst_n    (Reset),
      .b        (B[i]),
      .duration (Duration),
      .mode     (Mode),
      .xl       (XL[i]),
      .done     (Done[i])
    );
  end

endmodule

// File: tb/tb_laser_pulse_n.sv
// Directed bench for laser_pulse_n: a per-edge vector table on a no-cooldown
// instance, plus long-pulse and cooldown sequences written out by hand.
module tb_laser_pulse_n;

  logic       clk;
  logic       rst_n;
  logic [3:0] b;
  logic [7:0] dur;
  logic [1:0] mode;
  logic [3:0] xl, done;
  logic [3:0] xl_cd, done_cd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] b;
    logic [7:0] dur;
    logic [1:0] mode;
    logic [3:0] exp_xl;
    logic [3:0] exp_done;
    string      name;
  } vec_t;

  vec_t vecs[$];

  laser_pulse_n #(.CHANNELS(4), .CNT_W(8), .COOLDOWN(0)) dut (
    .CLK(clk), .Reset(rst_n), .B(b), .Duration(dur), .Mode(mode),
    .XL(xl), .Done(done)
  );

  laser_pulse_n #(.CHANNELS(4), .CNT_W(8), .COOLDOWN(3)) dut_cd (
    .CLK(clk), .Reset(rst_n), .B(b), .Duration(dur), .Mode(mode),
    .XL(xl_cd), .Done(done_cd)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Inputs change 1 ns after an edge; outputs are sampled 1 ns after the next.
  task automatic applyStimulus(input logic r, input logic [3:0] bv,
                               input logic [7:0] d, input logic [1:0] m);
    rst_n = r;
    b     = bv;
    dur   = d;
    mode  = m;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic r, input logic [3:0] bv, input logic [7:0] d,
                        input logic [1:0] m, input logic [3:0] ex,
                        input logic [3:0] ed, input string name);
    vec_t v;
    v.rst_n = r; v.b = bv; v.dur = d; v.mode = m;
    v.exp_xl = ex; v.exp_done = ed; v.name = name;
    vecs.push_back(v);
  endtask

  // Press B[0] at cycle 0 (and optionally again at cycle repress) and
  // measure the resulting XL[0]/Done[0] waveform on the no-cooldown DUT.
  task automatic runPulse(input string name, input logic [7:0] d,
                          input logic [1:0] m, input int repress,
                          input int exp_high);
    int   high, dones, first_low, done_at;
    logic other;
    high = 0; dones = 0; first_low = -1; done_at = -1; other = 1'b0;
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'b1, ((k == 0) || (k == repress)) ? 4'b0001 : 4'b0000, d, m);
      if (xl[0]) high++;
      else if (first_low < 0) first_low = k;
      if (done[0]) begin
        dones++;
        done_at = k;
      end
      if (xl[3:1] != 3'b000) other = 1'b1;
    end
    checkOutput({name, "_high"}, high, exp_high);
    checkOutput({name, "_first_low"}, first_low, exp_high);
    checkOutput({name, "_dones"}, dones, 1);
    checkOutput({name, "_done_at"}, done_at, exp_high);
    checkOutput({name, "_others"}, {31'b0, other}, 32'd0);
  endtask

  task automatic cdStep(input logic b0, input logic exp_xl, input logic exp_done,
                        input string name);
    applyStimulus(1'b1, {3'b000, b0}, 8'd16, 2'b00);
    checkOutput({name, "_xl"}, {31'b0, xl_cd[0]}, {31'b0, exp_xl});
    checkOutput({name, "_done"}, {31'b0, done_cd[0]}, {31'b0, exp_done});
  endtask

  initial begin
    rst_n = 1'b0; b = 4'b0; dur = 8'd0; mode = 2'b00;

    addVec(0, 4'h0, 8'd2,   2'd0, 4'h0, 4'h0, "reset0");
    addVec(0, 4'h0, 8'd2,   2'd0, 4'h0, 4'h0, "reset1");
    addVec(1, 4'h0, 8'd2,   2'd0, 4'h0, 4'h0, "idle");
    addVec(1, 4'h1, 8'd2,   2'd0, 4'h1, 4'h0, "press_d2");
    addVec(1, 4'h1, 8'd2,   2'd0, 4'h1, 4'h0, "d2_second");
    addVec(1, 4'h0, 8'd2,   2'd0, 4'h0, 4'h1, "d2_done");
    addVec(1, 4'h1, 8'd1,   2'd0, 4'h1, 4'h0, "b2b_press");
    addVec(1, 4'h0, 8'd1,   2'd0, 4'h0, 4'h1, "b2b_done");
    addVec(1, 4'h0, 8'd1,   2'd0, 4'h0, 4'h0, "quiet0");
    addVec(1, 4'hF, 8'd1,   2'd0, 4'hF, 4'h0, "all_press");
    addVec(1, 4'h0, 8'd1,   2'd0, 4'h0, 4'hF, "all_done");
    addVec(1, 4'h2, 8'd0,   2'd0, 4'h0, 4'h0, "dur0_press");
    addVec(1, 4'h0, 8'd3,   2'd0, 4'h0, 4'h0, "dur0_after");
    addVec(1, 4'h4, 8'd1,   2'd0, 4'h4, 4'h0, "held_press");
    addVec(1, 4'h4, 8'd1,   2'd0, 4'h0, 4'h4, "held_done");
    addVec(1, 4'h4, 8'd1,   2'd0, 4'h0, 4'h0, "held_no_retrig");
    addVec(1, 4'h0, 8'd1,   2'd0, 4'h0, 4'h0, "quiet1");
    addVec(1, 4'h1, 8'd3,   2'd3, 4'h1, 4'h0, "m11_press");
    addVec(1, 4'h0, 8'd3,   2'd3, 4'h1, 4'h0, "m11_on");
    addVec(1, 4'h1, 8'd3,   2'd3, 4'h1, 4'h0, "m11_ignored");
    addVec(1, 4'h0, 8'd3,   2'd3, 4'h0, 4'h1, "m11_done");
    addVec(1, 4'h0, 8'd3,   2'd3, 4'h0, 4'h0, "quiet2");
    addVec(1, 4'h1, 8'd2,   2'd1, 4'h1, 4'h0, "rt_press");
    addVec(1, 4'h0, 8'd2,   2'd1, 4'h1, 4'h0, "rt_on");
    addVec(1, 4'h1, 8'd2,   2'd1, 4'h1, 4'h0, "rt_reload");
    addVec(1, 4'h0, 8'd2,   2'd1, 4'h1, 4'h0, "rt_after");
    addVec(1, 4'h0, 8'd2,   2'd1, 4'h0, 4'h1, "rt_done");
    addVec(1, 4'h0, 8'd2,   2'd1, 4'h0, 4'h0, "quiet3");
    addVec(1, 4'h1, 8'd3,   2'd2, 4'h1, 4'h0, "cx_press");
    addVec(1, 4'h0, 8'd3,   2'd2, 4'h1, 4'h0, "cx_on");
    addVec(1, 4'h1, 8'd3,   2'd2, 4'h0, 4'h1, "cx_cancel");
    addVec(1, 4'h0, 8'd3,   2'd2, 4'h0, 4'h0, "quiet4");
    addVec(1, 4'h1, 8'd2,   2'd0, 4'h1, 4'h0, "latch_press");
    addVec(1, 4'h0, 8'd200, 2'd2, 4'h1, 4'h0, "latch_change");
    addVec(1, 4'h1, 8'd200, 2'd2, 4'h0, 4'h1, "latch_done");
    addVec(1, 4'h0, 8'd2,   2'd0, 4'h0, 4'h0, "quiet5");
    addVec(1, 4'h1, 8'd3,   2'd0, 4'h1, 4'h0, "mid_press");
    addVec(0, 4'h0, 8'd3,   2'd0, 4'h0, 4'h0, "mid_reset");
    addVec(1, 4'h0, 8'd3,   2'd0, 4'h0, 4'h0, "mid_after0");
    addVec(1, 4'h0, 8'd3,   2'd0, 4'h0, 4'h0, "mid_after1");
    addVec(1, 4'h0, 8'd3,   2'd0, 4'h0, 4'h0, "mid_after2");
    addVec(0, 4'hF, 8'd3,   2'd0, 4'h0, 4'h0, "held_rst");
    addVec(1, 4'hF, 8'd3,   2'd0, 4'h0, 4'h0, "held_release");
    addVec(1, 4'hF, 8'd3,   2'd0, 4'h0, 4'h0, "held_steady");
    addVec(1, 4'h0, 8'd3,   2'd0, 4'h0, 4'h0, "held_drop");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].b, vecs[i].dur, vecs[i].mode);
      checkOutput({vecs[i].name, "_xl"}, {28'b0, xl}, {28'b0, vecs[i].exp_xl});
      checkOutput({vecs[i].name, "_done"}, {28'b0, done}, {28'b0, vecs[i].exp_done});
    end

    runPulse("oneshot16", 8'd16, 2'b00, -1, 16);
    runPulse("retrig16", 8'd16, 2'b01, 10, 26);
    runPulse("cancel16", 8'd16, 2'b10, 5, 5);
    runPulse("max255", 8'd255, 2'b00, -1, 255);

    // Cooldown instance: pulse ends at cycle 16, COOL occupies cycles 17..19.
    cdStep(1'b1, 1'b1, 1'b0, "cd_press");
    for (int k = 1; k < 16; k++) cdStep(1'b0, 1'b1, 1'b0, "cd_on");
    cdStep(1'b0, 1'b0, 1'b1, "cd_done");
    cdStep(1'b1, 1'b0, 1'b0, "cd_press_after_done");
    cdStep(1'b0, 1'b0, 1'b0, "cd_cool");
    cdStep(1'b0, 1'b0, 1'b0, "cd_cool_end");
    cdStep(1'b1, 1'b1, 1'b0, "cd_press_ok");
    for (int k = 1; k < 16; k++) cdStep(1'b0, 1'b1, 1'b0, "cd_on2");
    cdStep(1'b0, 1'b0, 1'b1, "cd_done2");
    cdStep(1'b0, 1'b0, 1'b0, "cd_cool2a");
    cdStep(1'b0, 1'b0, 1'b0, "cd_cool2b");
    cdStep(1'b1, 1'b0, 1'b0, "cd_press_cool_end");
    cdStep(1'b0, 1'b0, 1'b0, "cd_idle");
    cdStep(1'b1, 1'b1, 1'b0, "cd_press_ok2");
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, 4'b0000, 8'd16, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/laser_pulse_n.md
LASER_PULSE_N -- requirements
Module: laser_pulse_n

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent button/laser channels (1..16).
REQ-002 Parameter CNT_W, default 8: width of the pulse-duration count.
REQ-003 Parameter COOLDOWN, default 0: lockout cycles after each pulse ends (0..255).
REQ-004 CLK  input  1: single system clock; all logic on its rising edge.
REQ-005 Reset  input  1: synchronous, active-low reset; sampled on the CLK rising edge.
REQ-006 B  input  CHANNELS: button levels, already conditioned by ButtonSync, one bit per channel.
REQ-007 Duration  input  CNT_W: pulse length in CLK cycles, shared by all channels.
REQ-008 Mode  input  2: 00 one-shot, 01 retrigger, 10 cancel, 11 treated as one-shot.
REQ-009 XL  output  CHANNELS: laser ON/OFF, registered, one bit per channel.
REQ-010 Done  output  CHANNELS: one-cycle pulse per channel marking the end of a laser pulse.

Function
REQ-011 Each channel SHALL run its own FSM with states IDLE, ON and COOL, independent of the other channels.
REQ-012 A press SHALL be detected at edge t when B[i] is 1 at t and was 0 at edge t-1.
REQ-013 In IDLE, a press with Duration>0 SHALL enter ON, latch Duration and Mode, and drive XL[i]=1 from edge t for exactly Duration cycles.
REQ-014 In IDLE, a press with Duration=0 SHALL be ignored: no XL, no Done, state unchanged.
REQ-015 When the ON count expires, XL[i] SHALL drop and Done[i] SHALL be 1 for exactly the first cycle XL[i] is 0.
REQ-016 After ON, the channel SHALL enter COOL for COOLDOWN cycles, or go straight to IDLE when COOLDOWN=0.
REQ-017 In COOL, presses SHALL be ignored; a press at the edge that ends COOL SHALL also be ignored.
REQ-018 In ON with latched mode one-shot, presses SHALL be ignored.
REQ-019 In ON with latched mode retrigger, a press SHALL reload the latched Duration, so XL stays 1 for Duration cycles from that press edge with no gap and no Done.
REQ-020 In ON with latched mode cancel, a press SHALL drop XL at that edge, assert Done for one cycle and proceed as in REQ-016.
REQ-021 Changes to Duration and Mode during ON SHALL NOT affect the pulse in progress.
REQ-022 The internal count SHALL be CNT_W bits; Duration = 2^CNT_W-1 SHALL be honoured with no wrap-around.
REQ-023 Simultaneous presses on several channels SHALL each be served in the same cycle.

Reset
REQ-024 While Reset=0 at an edge, every channel SHALL go to IDLE, with XL=0, Done=0 and count=0 after that edge.
REQ-025 The stored previous-B value SHALL reset to 1, so B held high across reset release does not trigger.
REQ-026 Reset asserted mid-pulse SHALL end the pulse at that edge without asserting Done.

Structure
REQ-027 Shared package laser_pkg SHALL hold the Mode encodings (ONE_SHOT, RETRIG, CANCEL) and the channel state enum.
REQ-028 One sub-module, laser_chan, SHALL implement a single channel; laser_pulse_n SHALL instantiate CHANNELS copies with a generate loop.

Verification (20 ns CLK, CHANNELS=4, CNT_W=8)
REQ-029 Reset low for 50 ns, Duration=16, Mode=00, one 20 ns press on B[0] -> XL[0] high for exactly 320 ns, Done[0] high for one cycle after it; the other XL bits stay 0.
REQ-030 Mode=01, Duration=16, second press 200 ns into the pulse -> XL[0] stays high for 520 ns in total, with one Done at the end.
REQ-031 Mode=10, Duration=16, second press 100 ns into the pulse -> XL[0] falls at that press edge and Done[0] pulses once.
REQ-032 COOLDOWN=3, press again in the cycle right after Done -> ignored; press 4 cycles after Done -> new 16-cycle pulse.
REQ-033 B[0] held at 1 through reset release -> no pulse; Duration=0 press -> no XL and no Done; Duration=255 -> 255-cycle pulse.
REQ-034 Reset driven low in the middle of a pulse -> XL=0 after the next edge and Done never asserted.
